// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM type and port-count limit for the N-port memory arbiter
package mem_arbiter_pkg;
  localparam int MAX_PORTS = 8;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// rr_picker: masked priority encoder, first requester at/after ptr (mode=1) or lowest index (mode=0)
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 mode,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);
  int base;
  logic [IDX_W-1:0] j;
  // scan offsets from the far end so the requester nearest the base wins
  always_comb begin
    base = mode ? int'(ptr) : 0;
    valid = |req;
    idx = '0;
    j = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = IDX_W'((base + i) % NUM_PORTS);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port memory bus arbiter, round-robin or fixed priority, with per-port grant lock
module mem_arbiter_n
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int ROUND_ROBIN = 1,
  parameter int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH:1]     m_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   m_data_out,
  input  logic [NUM_PORTS-1:0]                   m_access,
  input  logic [NUM_PORTS-1:0]                   m_wr_en,
  input  logic [NUM_PORTS-1:0][1:0]              m_bytesel,
  input  logic [NUM_PORTS-1:0]                   m_lock,
  output logic [DATA_WIDTH-1:0]                  m_data_in,
  output logic [NUM_PORTS-1:0]                   m_ack,
  output logic [ADDR_WIDTH:1]                    q_m_addr,
  output logic [DATA_WIDTH-1:0]                  q_m_data_out,
  input  logic [DATA_WIDTH-1:0]                  q_m_data_in,
  output logic                                   q_m_access,
  input  logic                                   q_m_ack,
  output logic                                   q_m_wr_en,
  output logic [1:0]                             q_m_bytesel,
  output logic [IDX_W-1:0]                       q_grant
);
  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("mem_arbiter_n: NUM_PORTS out of range");
  end
  arb_state_t state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_d, grant_d, pick_idx, win, next_ptr;
  logic locked, locked_d, pick_valid, busy, done;
  rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
    .req   (m_access),
    .ptr   (rr_ptr),
    .mode  (ROUND_ROBIN != 0),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
  assign busy = state == BUSY;
  assign done = busy & q_m_ack;
  assign win = (locked && m_access[q_grant]) ? q_grant : pick_idx;
  assign next_ptr = (q_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : q_grant + IDX_W'(1);
  assign q_m_access = busy;
  assign q_m_addr = busy ? m_addr[q_grant] : '0;
  assign q_m_data_out = busy ? m_data_out[q_grant] : '0;
  assign q_m_wr_en = busy & m_wr_en[q_grant];
  assign q_m_bytesel = busy ? m_bytesel[q_grant] : 2'b00;
  assign m_ack = done ? NUM_PORTS'(1) << q_grant : '0;
  assign m_data_in = q_m_data_in;
  // next state: grant a winner from IDLE, release on downstream completion
  always_comb begin
    state_d = state;
    grant_d = q_grant;
    rr_d = rr_ptr;
    locked_d = locked;
    if (!busy && pick_valid) begin
      state_d = BUSY;
      grant_d = win;
      locked_d = locked && win == q_grant;
    end else if (done) begin
      state_d = IDLE;
      rr_d = next_ptr;
      locked_d = m_lock[q_grant];
    end
  end
  // state and arbitration registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q_grant <= '0;
      rr_ptr <= '0;
      locked <= 1'b0;
    end else begin
      state <= state_d;
      q_grant <= grant_d;
      rr_ptr <= rr_d;
      locked <= locked_d;
    end
  end
endmodule
